// File: rtl/audio_seq_ctrl.sv
// rtl/audio_seq_ctrl.sv - sound sequencer: request arbitration, note timing, tone ROM addressing
module audio_seq_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int NOTE_TICKS = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] audio_select,
  input  logic       audio_enable,
  input  logic       abort,
  output logic [5:0] note_code,
  output logic       tone_en,
  output logic       seqEnd,
  output logic       busy,
  output logic [2:0] active_id
);

  // Counter widths are floored at 1 bit so degenerate parameters still elaborate.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int NW = (NOTE_TICKS > 0) ? $clog2(NOTE_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [NW-1:0] NOTE_LAST = NW'(NOTE_TICKS - 1);
  localparam logic [NW-1:0] NOTE_ONE  = NW'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    r_active_id;
  logic [2:0]    r_note_idx;
  logic [TW-1:0] r_tick_cnt;
  logic [NW-1:0] r_note_tick;
  logic          r_pend_valid;
  logic [2:0]    r_pend_id;

  logic [2:0] w_count;
  logic       w_req_valid;
  logic       w_busy;
  logic       w_preempt;
  logic       w_pend_wr;
  logic       w_tick_end;
  logic       w_last_note;

  // Notes per sound id; no-op ids report 1 so count-1 never underflows.
  function automatic logic [2:0] note_count(input logic [2:0] id);
    case (id)
      3'd2:    note_count = 3'd3;
      3'd3:    note_count = 3'd4;
      3'd4:    note_count = 3'd2;
      3'd5:    note_count = 3'd6;
      3'd6:    note_count = 3'd5;
      default: note_count = 3'd1;
    endcase
  endfunction

  assign w_count     = note_count(r_active_id);
  assign w_req_valid = audio_enable && (audio_select >= 3'd2) && (audio_select <= 3'd6);
  assign w_busy      = (r_state == S_LOAD) || (r_state == S_PLAY) || (r_state == S_GAP);
  assign w_preempt   = w_req_valid && w_busy && (audio_select >= 3'd5) && (audio_select > r_active_id);
  assign w_pend_wr   = w_req_valid && w_busy && !w_preempt &&
                       (!r_pend_valid || (audio_select > r_pend_id));
  assign w_tick_end  = (r_tick_cnt == TICK_LAST);
  assign w_last_note = (r_note_idx == (w_count - 3'd1));

  assign seqEnd    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy      = ~seqEnd;
  assign tone_en   = (r_state == S_PLAY);
  assign active_id = r_active_id;
  assign note_code = {r_active_id, r_note_idx};

  // Sequencer state, note/tick counters and the one-deep pending request slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_active_id  <= 3'd0;
      r_note_idx   <= 3'd0;
      r_tick_cnt   <= '0;
      r_note_tick  <= '0;
      r_pend_valid <= 1'b0;
      r_pend_id    <= 3'd0;
    end else if (abort) begin
      r_state      <= S_IDLE;
      r_active_id  <= 3'd0;
      r_note_idx   <= 3'd0;
      r_tick_cnt   <= '0;
      r_note_tick  <= '0;
      r_pend_valid <= 1'b0;
      r_pend_id    <= 3'd0;
    end else begin
      if (w_pend_wr) begin
        r_pend_valid <= 1'b1;
        r_pend_id    <= audio_select;
      end
      if (w_preempt) begin
        // A higher-priority sound restarts from LOAD; the interrupted one is dropped.
        r_state     <= S_LOAD;
        r_active_id <= audio_select;
        r_note_idx  <= 3'd0;
        r_tick_cnt  <= '0;
        r_note_tick <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_req_valid) begin
              r_state     <= S_LOAD;
              r_active_id <= audio_select;
              r_note_idx  <= 3'd0;
              r_tick_cnt  <= '0;
              r_note_tick <= '0;
            end
          end
          S_LOAD: begin
            r_state     <= S_PLAY;
            r_note_idx  <= 3'd0;
            r_tick_cnt  <= '0;
            r_note_tick <= '0;
          end
          S_PLAY: begin
            if (w_tick_end) begin
              r_tick_cnt <= '0;
              if (r_note_tick == NOTE_LAST) begin
                r_note_tick <= '0;
                r_state     <= w_last_note ? S_DONE : S_GAP;
              end else begin
                r_note_tick <= r_note_tick + NOTE_ONE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_ONE;
            end
          end
          S_GAP: begin
            if (w_tick_end) begin
              r_tick_cnt <= '0;
              r_note_idx <= r_note_idx + 3'd1;
              r_state    <= S_PLAY;
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_ONE;
            end
          end
          S_DONE: begin
            // A fresh request beats the pending slot, which is then kept for later.
            r_note_idx  <= 3'd0;
            r_tick_cnt  <= '0;
            r_note_tick <= '0;
            if (w_req_valid) begin
              r_state     <= S_LOAD;
              r_active_id <= audio_select;
            end else if (r_pend_valid) begin
              r_state      <= S_LOAD;
              r_active_id  <= r_pend_id;
              r_pend_valid <= 1'b0;
            end else begin
              r_state     <= S_IDLE;
              r_active_id <= 3'd0;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_active_id <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_seq_ctrl.sv
// tb/tb_audio_seq_ctrl.sv - directed table-driven bench for audio_seq_ctrl
module tb_audio_seq_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] audio_select;
  logic       audio_enable;
  logic       abort;
  logic [5:0] note_code;
  logic       tone_en;
  logic       seqEnd;
  logic       busy;
  logic [2:0] active_id;

  audio_seq_ctrl #(.TICK_DIV(4), .NOTE_TICKS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .audio_select (audio_select),
    .audio_enable (audio_enable),
    .abort        (abort),
    .note_code    (note_code),
    .tone_en      (tone_en),
    .seqEnd       (seqEnd),
    .busy         (busy),
    .active_id    (active_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] sel;
    int         low;
    int         n;
    int         first;
  } vec_t;

  vec_t tbl[8];
  int   n_checks = 0;
  int   n_errors = 0;

  bit rec;
  bit prev_tone;
  int low_cnt, off_run, hi_run;
  int q_codes[$];
  int q_hi[$];
  int q_off[$];
  int e_codes[$];
  int e_off[$];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_rec();
    low_cnt = 0; off_run = 0; hi_run = 0; prev_tone = 1'b0;
    q_codes.delete(); q_hi.delete(); q_off.delete();
  endtask

  // Samples outputs just after the falling edge, before inputs are changed.
  task automatic sample();
    if (!seqEnd) low_cnt++;
    if (tone_en && !prev_tone) begin
      q_codes.push_back(int'(note_code));
      if (off_run > 0) q_off.push_back(off_run);
      off_run = 0;
      hi_run  = 0;
    end
    if (tone_en) hi_run++;
    if (!tone_en && prev_tone) q_hi.push_back(hi_run);
    if (busy && !tone_en) off_run++;
    prev_tone = tone_en;
  endtask

  task automatic tick();
    @(negedge clk);
    if (rec) sample();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [2:0] sel);
    tick();
    audio_select = sel;
    audio_enable = 1'b1;
    tick();
    audio_enable = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int hi;
    bit ok;
    hi = 0;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      tick();
      if (seqEnd) hi++; else hi = 0;
      if (hi >= 2) ok = 1'b1;
    end
    check({name, " reaches idle"}, int'(ok), 1);
  endtask

  task automatic verify(input string name, input int exp_low);
    check({name, " seqEnd-low cycles"}, low_cnt, exp_low);
    check({name, " note count"}, q_codes.size(), e_codes.size());
    for (int i = 0; i < e_codes.size() && i < q_codes.size(); i++)
      check($sformatf("%s note_code[%0d]", name, i), q_codes[i], e_codes[i]);
    check({name, " tone pulses"}, q_hi.size(), e_codes.size());
    for (int i = 0; i < q_hi.size(); i++)
      check($sformatf("%s tone length[%0d]", name, i), q_hi[i], 8);
    check({name, " off runs"}, q_off.size(), e_off.size());
    for (int i = 0; i < e_off.size() && i < q_off.size(); i++)
      check($sformatf("%s off run[%0d]", name, i), q_off[i], e_off[i]);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " note_code"}, int'(note_code), 0);
    check({name, " tone_en"},   int'(tone_en), 0);
    check({name, " seqEnd"},    int'(seqEnd), 1);
    check({name, " busy"},      int'(busy), 0);
    check({name, " active_id"}, int'(active_id), 0);
  endtask

  initial begin
    tbl[0] = '{3'd4, 21, 2, 8'h20};
    tbl[1] = '{3'd2, 33, 3, 8'h10};
    tbl[2] = '{3'd3, 45, 4, 8'h18};
    tbl[3] = '{3'd5, 69, 6, 8'h28};
    tbl[4] = '{3'd6, 57, 5, 8'h30};
    tbl[5] = '{3'd0, 0, 0, 0};
    tbl[6] = '{3'd1, 0, 0, 0};
    tbl[7] = '{3'd7, 0, 0, 0};

    rec = 1'b0;
    clear_rec();
    audio_select = 3'd0;
    audio_enable = 1'b0;
    abort        = 1'b0;
    rst          = 1'b0;
    #3;
    check_reset_outputs("reset");
    ticks(2);

    // First edge after release accepts a request.
    rst          = 1'b1;
    audio_select = 3'd4;
    audio_enable = 1'b1;
    tick();
    audio_enable = 1'b0;
    check("first edge active_id", int'(active_id), 4);
    check("first edge busy", int'(busy), 1);
    wait_idle("first edge");

    // Single sounds pulsed from IDLE.
    for (int v = 0; v < 8; v++) begin
      e_codes.delete();
      e_off.delete();
      for (int k = 0; k < tbl[v].n; k++) begin
        e_codes.push_back(tbl[v].first + k);
        e_off.push_back(k == 0 ? 1 : 4);
      end
      clear_rec();
      rec = 1'b1;
      pulse(tbl[v].sel);
      wait_idle($sformatf("id%0d", tbl[v].sel));
      rec = 1'b0;
      verify($sformatf("id%0d", tbl[v].sel), tbl[v].low);
    end

    // Low-priority request queues behind the playing sound.
    clear_rec(); rec = 1'b1;
    pulse(3'd2); ticks(6); pulse(3'd3);
    wait_idle("queue");
    rec = 1'b0;
    e_codes = '{8'h10, 8'h11, 8'h12, 8'h18, 8'h19, 8'h1A, 8'h1B};
    e_off   = '{1, 4, 4, 1, 4, 4, 4};
    verify("queue", 78);

    // High-priority request preempts during a gap.
    clear_rec(); rec = 1'b1;
    pulse(3'd3); ticks(10); pulse(3'd6);
    check("preempt active_id", int'(active_id), 6);
    check("preempt note_code", int'(note_code), 8'h30);
    check("preempt busy", int'(busy), 1);
    wait_idle("preempt");
    rec = 1'b0;
    e_codes = '{8'h18, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
    e_off   = '{1, 4, 4, 4, 4, 4};
    verify("preempt", 69);

    // Pending slot keeps the highest id; lower requests are dropped.
    clear_rec(); rec = 1'b1;
    pulse(3'd2); ticks(3); pulse(3'd2); pulse(3'd4); pulse(3'd3);
    wait_idle("pending");
    rec = 1'b0;
    e_codes = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21};
    e_off   = '{1, 4, 4, 1, 4};
    verify("pending", 54);

    // Request landing on DONE wins over the pending entry, which still plays after.
    clear_rec(); rec = 1'b1;
    pulse(3'd4); ticks(2); pulse(3'd3); ticks(16);
    tick();
    check("done-edge seqEnd", int'(seqEnd), 1);
    check("done-edge note_code", int'(note_code), 8'h21);
    audio_select = 3'd2;
    audio_enable = 1'b1;
    tick();
    audio_enable = 1'b0;
    check("done-edge active_id", int'(active_id), 2);
    wait_idle("done-edge");
    rec = 1'b0;
    e_codes = '{8'h20, 8'h21, 8'h10, 8'h11, 8'h12, 8'h18, 8'h19, 8'h1A, 8'h1B};
    e_off   = '{1, 4, 1, 4, 4, 1, 4, 4, 4};
    verify("done-edge", 99);

    // Abort during a gap discards the active and pending sounds.
    clear_rec(); rec = 1'b1;
    pulse(3'd2); ticks(3); pulse(3'd3); ticks(5);
    tick();
    check("abort in gap tone_en", int'(tone_en), 0);
    abort        = 1'b1;
    audio_select = 3'd6;
    audio_enable = 1'b1;
    tick();
    abort        = 1'b0;
    audio_enable = 1'b0;
    check_reset_outputs("abort");
    ticks(40);
    rec = 1'b0;
    e_codes = '{8'h10};
    e_off   = '{1};
    verify("abort", 12);

    // Asynchronous reset mid-note, then no-op ids stay idle.
    pulse(3'd4); pulse(3'd3); ticks(3);
    check("pre-reset tone_en", int'(tone_en), 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async reset");
    ticks(2);
    rst = 1'b1;
    clear_rec(); rec = 1'b1;
    pulse(3'd1); pulse(3'd7); ticks(30);
    rec = 1'b0;
    check("post-reset low cycles", low_cnt, 0);
    check("post-reset active_id", int'(active_id), 0);
    check("post-reset notes", q_codes.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
